slave_axi_writer: RTL and testbench

SLAVE_AXI_WRITER -- requirements
Module: slave_axi_writer

---
 rtl/slave_axi_writer.sv | 196 +++++++++++++++++++
 tb/tb_slave_axi_writer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_axi_writer.sv
// AXI read-channel slave: accepts one armed read burst, fetches beats from a
// per-beat engine interface and returns them on the R channel via a 2-entry FIFO.
module slave_axi_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // AR channel
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    // R channel
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    // engine
    input  logic                  eng_start,
    output logic                  eng_req_valid,
    input  logic                  eng_req_ready,
    output logic [ADDR_WIDTH-1:0] eng_req_addr,
    input  logic                  eng_data_valid,
    input  logic [DATA_WIDTH-1:0] eng_data,
    input  logic [1:0]            eng_resp,
    output logic                  eng_data_ready,
    // status
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Every handshake (AR, R, eng_req, eng_data) completes on a rising edge where
    // valid and ready are both high; a valid source holds its payload until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [3:0]            lat_len;
    logic [2:0]            lat_size;
    logic [1:0]            lat_burst;
    logic [4:0]            issued;
    logic [4:0]            rcount;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_resp [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            fifo_cnt;

    logic [4:0]            beats;
    logic [4:0]            outstanding;
    logic                  ar_illegal;
    logic                  req_hs;
    logic                  push;
    logic                  pop;
    logic                  r_hs;
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] wrap_base;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign beats       = {1'b0, lat_len} + 5'd1;
    assign outstanding = issued - rcount;
    assign ar_illegal  = (arsize > 3'd2) || (arburst == 2'b11) ||
                         ((arburst == 2'b10) && !(arlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

    assign busy           = (state != IDLE);
    assign dbg_state      = state;
    assign eng_req_valid  = (state == DATA) && (issued < beats) && (outstanding < 5'd2);
    assign eng_req_addr   = req_addr;
    assign eng_data_ready = (state == DATA) && (fifo_cnt != 2'd2);
    assign rvalid         = ((state == DATA) && (fifo_cnt != 2'd0)) || (state == ERR);
    assign rdata          = (state == DATA) ? fifo_data[rd_ptr] : '0;
    assign rresp          = (state == DATA) ? fifo_resp[rd_ptr] :
                            (state == ERR)  ? 2'b10 : 2'b00;
    assign rlast          = rvalid && (rcount == {1'b0, lat_len});

    assign req_hs = eng_req_valid && eng_req_ready;
    assign push   = eng_data_valid && eng_data_ready;
    assign r_hs   = rvalid && rready;
    assign pop    = r_hs && (state == DATA);

    // Wrap span is a power of two for every legal WRAP burst, so masks stand in for mod.
    assign bytes     = ADDR_WIDTH'(1) << lat_size;
    assign span      = ADDR_WIDTH'(beats) << lat_size;
    assign wrap_base = base_addr & ~(span - ADDR_WIDTH'(1));

    always_comb begin
        next_addr = req_addr;
        case (lat_burst)
            2'b00:   next_addr = base_addr;
            2'b01:   next_addr = (req_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            2'b10:   next_addr = wrap_base +
                                 ((req_addr + bytes - wrap_base) & (span - ADDR_WIDTH'(1)));
            default: next_addr = req_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            arready   <= 1'b0;
            rid       <= '0;
            base_addr <= '0;
            req_addr  <= '0;
            lat_len   <= '0;
            lat_size  <= '0;
            lat_burst <= '0;
            issued    <= '0;
            rcount    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            fifo_cnt  <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_resp[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= eng_data;
                fifo_resp[wr_ptr] <= eng_resp;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            case (state)
                IDLE: begin
                    if (eng_start) begin
                        state   <= AR;
                        arready <= 1'b1;
                    end
                end
                AR: begin
                    if (arvalid) begin
                        arready   <= 1'b0;
                        rid       <= arid;
                        base_addr <= araddr;
                        req_addr  <= araddr;
                        lat_len   <= arlen;
                        lat_size  <= arsize;
                        lat_burst <= arburst;
                        issued    <= '0;
                        rcount    <= '0;
                        rd_ptr    <= 1'b0;
                        wr_ptr    <= 1'b0;
                        fifo_cnt  <= '0;
                        state     <= ar_illegal ? ERR : DATA;
                    end
                end
                DATA: begin
                    if (req_hs) begin
                        req_addr <= next_addr;
                        issued   <= issued + 5'd1;
                    end
                    if (r_hs) begin
                        rcount <= rcount + 5'd1;
                        if (rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (r_hs) begin
                        rcount <= rcount + 5'd1;
                        if (rlast) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_axi_writer.sv
// Randomized bench for slave_axi_writer: an engine model feeds beats, and the
// expected address and R-beat sequences come from the burst arithmetic.
module tb_slave_axi_writer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        eng_start;
    logic        eng_req_valid;
    logic        eng_req_ready;
    logic [31:0] eng_req_addr;
    logic        eng_data_valid;
    logic [31:0] eng_data;
    logic [1:0]  eng_resp;
    logic        eng_data_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    slave_axi_writer dut (
        .clk(clk), .rst_n(rst_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .eng_start(eng_start), .eng_req_valid(eng_req_valid),
        .eng_req_ready(eng_req_ready), .eng_req_addr(eng_req_addr),
        .eng_data_valid(eng_data_valid), .eng_data(eng_data),
        .eng_resp(eng_resp), .eng_data_ready(eng_data_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  resp;
    } eng_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    eng_t        eng_q[$];
    logic [33:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [1:0]  resp_tab[16];

    int          cur_len, cur_id, n_req, n_r, last_due;
    int          lat_min, lat_max, rready_pct, ereq_pct;
    int          stall_beat, stall_left;
    bit          started;
    bit          stab_r, stab_a;
    logic [31:0] held_rdata, held_addr;
    logic [1:0]  held_rresp;
    logic        held_rlast;

    logic        drv_start, drv_arvalid;
    logic [3:0]  drv_arid, drv_arlen;
    logic [31:0] drv_araddr;
    logic [2:0]  drv_arsize;
    logic [1:0]  drv_arburst;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Address of beat i computed directly from the burst definition.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input int size, input int burst, input int i);
        logic [31:0] nbytes, span, base, ofs;
        nbytes = 32'd1 << size;
        span   = 32'(len + 1) * nbytes;
        base   = a - (a % span);
        ofs    = 32'(i) * nbytes;
        case (burst)
            0:       return a;
            1:       return (i == 0) ? a : (a - (a % nbytes)) + ofs;
            default: return base + ((a - base + ofs) % span);
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_arready"}, 64'(arready), 0);
        check_eq({tag, "_rvalid"}, 64'(rvalid), 0);
        check_eq({tag, "_rlast"}, 64'(rlast), 0);
        check_eq({tag, "_eng_req_valid"}, 64'(eng_req_valid), 0);
        check_eq({tag, "_busy"}, 64'(busy), 0);
        check_eq({tag, "_rid"}, 64'(rid), 0);
        check_eq({tag, "_rdata"}, 64'(rdata), 0);
        check_eq({tag, "_rresp"}, 64'(rresp), 0);
        check_eq({tag, "_eng_req_addr"}, 64'(eng_req_addr), 0);
        check_eq({tag, "_eng_data_ready"}, 64'(eng_data_ready), 0);
        check_eq({tag, "_state"}, 64'(dbg_state), 0);
    endtask

    // One clock: drive after the rising edge, observe at the falling edge.
    task automatic tick();
        eng_t        e;
        logic [33:0] x;
        int          lat;
        @(posedge clk);
        #1;
        cyc++;
        eng_start = drv_start;
        arvalid   = drv_arvalid;
        arid      = drv_arid;
        araddr    = drv_araddr;
        arlen     = drv_arlen;
        arsize    = drv_arsize;
        arburst   = drv_arburst;
        if (stall_left > 0 && n_r >= stall_beat) begin
            rready = 1'b0;
            stall_left--;
        end else begin
            rready = ($urandom_range(99) < rready_pct);
        end
        eng_req_ready = ($urandom_range(99) < ereq_pct);
        if (eng_q.size() > 0 && eng_q[0].due <= cyc) begin
            eng_data_valid = 1'b1;
            eng_data       = eng_q[0].data;
            eng_resp       = eng_q[0].resp;
        end else begin
            eng_data_valid = 1'b0;
            eng_data       = $urandom;
            eng_resp       = 2'($urandom_range(3));
        end

        @(negedge clk);
        if (stab_r) begin
            check_eq("r_hold_valid", 64'(rvalid), 1);
            check_eq("r_hold_data", 64'(rdata), 64'(held_rdata));
            check_eq("r_hold_resp", 64'(rresp), 64'(held_rresp));
            check_eq("r_hold_last", 64'(rlast), 64'(held_rlast));
        end
        stab_r     = rvalid && !rready;
        held_rdata = rdata;
        held_rresp = rresp;
        held_rlast = rlast;
        if (stab_a && eng_req_valid)
            check_eq("req_addr_hold", 64'(eng_req_addr), 64'(held_addr));
        stab_a    = eng_req_valid && !eng_req_ready;
        held_addr = eng_req_addr;

        if (eng_req_valid && eng_req_ready) begin
            check_eq("req_outstanding_lt2", 64'(n_req - n_r < 2), 1);
            if (exp_addr_q.size() == 0) check_eq("req_unexpected", 64'(eng_req_addr), 64'hdead_0000);
            else check_eq("req_addr", 64'(eng_req_addr), 64'(exp_addr_q.pop_front()));
            lat    = $urandom_range(lat_max, lat_min);
            e.due  = (cyc + lat > last_due) ? cyc + lat : last_due;
            e.data = $urandom;
            e.resp = resp_tab[n_req % 16];
            last_due = e.due;
            eng_q.push_back(e);
            exp_q.push_back({e.resp, e.data});
            n_req++;
        end
        if (eng_data_valid && eng_data_ready && eng_q.size() > 0)
            void'(eng_q.pop_front());
        if (rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check_eq("r_unexpected", 64'({rresp, rdata}), 64'h3_dead_beef);
            end else begin
                x = exp_q.pop_front();
                check_eq("rdata", 64'(rdata), 64'(x[31:0]));
                check_eq("rresp", 64'(rresp), 64'(x[33:32]));
            end
            check_eq("rlast", 64'(rlast), 64'(n_r == cur_len));
            check_eq("rid", 64'(rid), 64'(cur_id));
            n_r++;
        end
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid");
        exp_q.delete();
        exp_addr_q.delete();
        stab_r = 1'b0;
        stab_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_data_ready", 64'(eng_data_ready), 0);
            check_eq("post_rst_busy", 64'(busy), 0);
        end
        eng_q.delete();
        stab_r = 1'b0;
        stab_a = 1'b0;
    endtask

    task automatic run_burst(input int id, input logic [31:0] addr, input int len,
                             input int size, input int burst, input int rst_beat,
                             input bit chain);
        bit illegal;
        int budget;
        cur_len  = len;
        cur_id   = id;
        n_req    = 0;
        n_r      = 0;
        last_due = 0;
        drv_start = 1'b0;
        illegal = (size > 2) || (burst == 3) ||
                  (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int i = 0; i <= len; i++) begin
            if (illegal) exp_q.push_back({2'b10, 32'h0});
            else exp_addr_q.push_back(model_addr(addr, len, size, burst, i));
        end
        if (!started) begin
            drv_start = 1'b1;
            tick();
            drv_start = 1'b0;
        end
        started     = 1'b0;
        drv_arvalid = 1'b1;
        drv_arid    = 4'(id);
        drv_araddr  = addr;
        drv_arlen   = 4'(len);
        drv_arsize  = 3'(size);
        drv_arburst = 2'(burst);
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!arready && budget < 20);
        check_eq("ar_ready_seen", 64'(arready), 1);
        check_eq("ar_busy", 64'(busy), 1);
        drv_arvalid = 1'b0;
        tick();
        if (illegal) check_eq("first_cycle_rvalid", 64'(rvalid), 1);
        else         check_eq("first_cycle_req_valid", 64'(eng_req_valid), 1);
        budget = 0;
        while (n_r < len + 1 && budget < 600) begin
            if (rst_beat >= 0 && n_r >= rst_beat) begin
                mid_reset();
                return;
            end
            tick();
            budget++;
        end
        check_eq("burst_timeout", 64'(budget < 600), 1);
        check_eq("addr_left", 64'(exp_addr_q.size()), 0);
        check_eq("beats_left", 64'(exp_q.size()), 0);
        check_eq("req_count", 64'(n_req), illegal ? 0 : 64'(len + 1));
        exp_q.delete();
        exp_addr_q.delete();
        drv_start = chain;
        tick();
        drv_start = 1'b0;
        started   = chain;
        check_eq("end_busy", 64'(busy), 0);
        check_eq("end_rvalid", 64'(rvalid), 0);
        check_eq("end_req_valid", 64'(eng_req_valid), 0);
    endtask

    task automatic set_mode(input int lmin, input int lmax, input int rp, input int ep);
        lat_min    = lmin;
        lat_max    = lmax;
        rready_pct = rp;
        ereq_pct   = ep;
        stall_left = 0;
        stall_beat = 0;
        foreach (resp_tab[i]) resp_tab[i] = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        {eng_start, arvalid, rready, eng_req_ready, eng_data_valid} = '0;
        {arid, araddr, arlen, arsize, arburst, eng_data, eng_resp} = '0;
        {drv_start, drv_arvalid, drv_arid, drv_araddr, drv_arlen, drv_arsize, drv_arburst} = '0;
        started = 1'b0;
        stab_r  = 1'b0;
        stab_a  = 1'b0;
        set_mode(1, 1, 100, 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // INCR 4 beats, single-cycle engine, always-ready sink
        set_mode(1, 1, 100, 100);
        run_burst(3, 32'h100, 3, 2, 1, -1, 1'b0);
        // WRAP 4 beats starting mid-span
        run_burst(5, 32'h108, 3, 2, 2, -1, 1'b0);
        // R sink stalls for 5 cycles after two beats
        set_mode(1, 2, 100, 100);
        stall_beat = 2;
        stall_left = 5;
        run_burst(6, 32'h400, 7, 2, 1, -1, 1'b0);
        // illegal size: error beats only
        set_mode(1, 1, 100, 100);
        run_burst(9, 32'h500, 1, 3, 1, -1, 1'b0);
        // FIXED with a slave error on beat 1
        set_mode(1, 2, 100, 100);
        resp_tab[1] = 2'b10;
        run_burst(2, 32'h203, 2, 0, 0, -1, 1'b1);
        // back-to-back minimum burst started right after the last R beat
        set_mode(1, 1, 100, 100);
        run_burst(7, 32'h0, 0, 2, 1, -1, 1'b0);
        // reset in the middle of an 8-beat burst, then a clean burst
        set_mode(2, 3, 100, 100);
        run_burst(4, 32'h600, 7, 2, 1, 2, 1'b0);
        set_mode(1, 2, 100, 100);
        run_burst(1, 32'h700, 3, 1, 1, -1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            set_mode(1, $urandom_range(4, 1), $urandom_range(100, 30), $urandom_range(100, 30));
            foreach (resp_tab[i]) resp_tab[i] = 2'($urandom_range(3));
            run_burst($urandom_range(15), $urandom, $urandom_range(15), $urandom_range(3),
                      $urandom_range(3), -1, 1'($urandom_range(1)));
        end
        if (started) begin
            started = 1'b0;
            run_burst(0, 32'hffff_fff8, 3, 2, 1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
